exc_pipe_tracker: RTL and testbench
===================================

// Module: exc_pipe_tracker
// PURPOSE
//  Parametrised exception-carry pipeline: walks exccode/bd/pc of each in-flight instruction through
//  NUM_STAGES registered stages, merges exceptions raised at each stage (oldest detection wins) and
//  commits at the final stage into EPC/Cause/EXL. Replaces the per-stage combinational exccode
//  pass-through; also generates the pipeline flush on exception entry.
// PARAMETERS
//  NUM_STAGES  3   tracked stages after D (0=E,1=M,2=W); legal 2..6
//  CODE_W      5   exception code width (MIPS Cause.ExcCode)
//  PC_W        32  program-counter width
// PORTS
//  clk          in   1                  clock, rising edge
//  reset_n      in   1                  asynchronous, active-low reset
//  instr_vld_d  in   1                  instruction leaving D is valid
//  pc_d         in   PC_W               its PC
//  bd_d         in   1                  it sits in a branch delay slot
//  exc_req      in   NUM_STAGES         per-stage new-exception flag, bit i = stage i
//  exc_code     in   NUM_STAGES*CODE_W  per-stage code, slice [i*CODE_W +: CODE_W]
//  stall        in   1                  freeze stages 0..NUM_STAGES-2
//  eret         in   1                  ERET committing in final stage
//  hw_int       in   6                  hardware interrupt lines (used only with EXC_INT_EN)
//  im_ie        in   7                  {IM[5:0],IE} (used only with EXC_INT_EN)
//  exc_commit   out  1                  final stage commits an exception this cycle (comb)
//  flush        out  1                  = exc_commit | eret; kills all younger stages
//  cause_code   out  CODE_W             registered Cause.ExcCode
//  cause_bd     out  1                  registered Cause.BD
//  epc          out  PC_W               registered EPC
//  exl          out  1                  registered Status.EXL
// BEHAVIOUR
//  - Per stage i: regs vld[i], pend[i], code[i], bd[i], pc[i]. Reset: all 0; all outputs 0.
//  - Merged view m_i: if pend[i] keep code[i]; else if vld[i]&exc_req[i] take exc_code slice i.
//    Older (earlier-stage) exception always wins over a later-stage one for the same instruction.
//  - Stage 0 loads {instr_vld_d,0,0,bd_d,pc_d}; stage i+1 loads merged m_i. Latency 1 cycle/stage.
//  - stall=1: stages 0..N-2 hold; final stage loads a bubble (vld=0). Final stage never stalls.
//  - Commit: exc_commit = vld[N-1] & (merged pend at N-1). Same cycle: flush=1.
//    Next edge: all vld/pend cleared (stage 0 load suppressed even if instr_vld_d=1);
//    cause_code<=code, cause_bd<=bd; if exl=0: epc<=bd ? pc-4 : pc (mod 2^PC_W, wraps), exl<=1;
//    if exl=1 (nested): cause updated, epc unchanged, exl stays 1.
//  - eret (with no commit): flush=1, younger stages cleared next edge, exl<=0.
//  - eret and exc_commit same cycle: commit wins; exl remains/becomes 1.
//  - flush has priority over stall. Bubbles (vld=0) never commit, even with exc_req set.
//  - Reset asserted mid-operation: all state cleared immediately, no commit, flush=0.
// CONFIGURATION
//  EXC_INT_EN defined: int_take = |(hw_int & im_ie[6:1]) & im_ie[0] & ~exl & vld[N-1].
//    int_take overrides any pending code: commit with code 0 (Int), epc = bd ? pc-4 : pc of that
//    (not completed) instruction; eret in same cycle loses as for exceptions.
//  EXC_INT_EN undefined: hw_int/im_ie ignored; code 0 only via exc_req.
// TESTING
//  1 reset_n=0 then release, idle -> all outputs 0, flush=0 for 10 cycles.
//  2 pc_d=0x3000, exc_req[1] code 0x0C (Ov) -> commit 2 cycles after stage 0 load; epc=0x3000,
//    cause_code=0x0C, exl=1; next instruction (0x3004) never commits.
//  3 same instr: exc_req[0] code 0x04 (AdEL), exc_req[1] code 0x0C -> cause_code=0x04 (oldest wins).
//  4 bd_d=1, pc_d=0x3008, exc at stage 2 -> epc=0x3004, cause_bd=1; then second exc with exl=1
//    -> cause_code updated, epc still 0x3004; eret -> exl=0, flush=1 one cycle.
//  5 stall=1 for 3 cycles with exc pending in stage 0 -> no commit while held, bubbles drain final
//    stage; commit occurs 2 cycles after stall drops.
//  6 EXC_INT_EN: im_ie=7'b0000011, hw_int[0]=1, exl=0, valid final instr pc=0x3010
//    -> commit code 0, epc=0x3010; with exl=1 -> no commit.

Source files
------------

// File: rtl/exc_pipe_tracker_if.sv
// exc_pipe_tracker_if: D-stage instruction feed, per-stage exception flags,
// stall/eret control and the CP0 results (EPC/Cause/EXL) plus flush.
// master = pipeline control side, slave = exc_pipe_tracker.
interface exc_pipe_tracker_if #(
  parameter int NUM_STAGES = 3,
  parameter int CODE_W     = 5,
  parameter int PC_W       = 32
) ();
  logic                         instr_vld_d;
  logic [PC_W-1:0]              pc_d;
  logic                         bd_d;
  logic [NUM_STAGES-1:0]        exc_req;
  logic [NUM_STAGES*CODE_W-1:0] exc_code;
  logic                         stall;
  logic                         eret;
  logic [5:0]                   hw_int;
  logic [6:0]                   im_ie;
  logic                         exc_commit;
  logic                         flush;
  logic [CODE_W-1:0]            cause_code;
  logic                         cause_bd;
  logic [PC_W-1:0]              epc;
  logic                         exl;

  modport master (
    output instr_vld_d, pc_d, bd_d, exc_req, exc_code, stall, eret, hw_int, im_ie,
    input  exc_commit, flush, cause_code, cause_bd, epc, exl
  );

  modport slave (
    input  instr_vld_d, pc_d, bd_d, exc_req, exc_code, stall, eret, hw_int, im_ie,
    output exc_commit, flush, cause_code, cause_bd, epc, exl
  );
endinterface

// File: rtl/exc_pipe_tracker.sv
// exc_pipe_tracker: carries valid/pending-exception/code/bd/pc of each
// in-flight instruction through NUM_STAGES registered stages, merges newly
// raised exceptions (oldest detection wins), commits at the final stage into
// EPC/Cause/EXL and raises flush on exception entry or ERET.
// Optional feature macro: EXC_INT_EN (hardware interrupts taken at the final
// stage with code 0). Default build ignores hw_int/im_ie.
module exc_pipe_tracker #(
  parameter int NUM_STAGES = 3,
  parameter int CODE_W     = 5,
  parameter int PC_W       = 32
) (
  input logic               clk,
  input logic               reset_n,
  exc_pipe_tracker_if.slave bus
);
  localparam int LAST = NUM_STAGES - 1;

  typedef struct packed {
    logic              vld;
    logic              pend;
    logic [CODE_W-1:0] code;
    logic              bd;
    logic [PC_W-1:0]   pc;
  } stage_t;

  stage_t [NUM_STAGES-1:0] r_stg;
  stage_t [NUM_STAGES-1:0] w_mrg;

  logic              w_int_take;
  logic              w_exc_commit;
  logic              w_flush;
  logic [CODE_W-1:0] w_commit_code;
  logic [PC_W-1:0]   w_epc_nxt;

  logic [CODE_W-1:0] r_cause_code;
  logic              r_cause_bd;
  logic [PC_W-1:0]   r_epc;
  logic              r_exl;

  // merged view: a held pending code is never overwritten by a younger detection
  always_comb begin
    w_mrg = r_stg;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (!r_stg[i].pend && r_stg[i].vld && bus.exc_req[i]) begin
        w_mrg[i].pend = 1'b1;
        w_mrg[i].code = bus.exc_code[i*CODE_W +: CODE_W];
      end
    end
  end

`ifdef EXC_INT_EN
  assign w_int_take = (|(bus.hw_int & bus.im_ie[6:1])) & bus.im_ie[0] & ~r_exl & r_stg[LAST].vld;
`else
  logic w_unused_irq;
  assign w_unused_irq = ^{bus.hw_int, bus.im_ie};
  assign w_int_take   = 1'b0;
`endif

  // interrupt overrides whatever code the final-stage instruction carries
  assign w_exc_commit  = (w_mrg[LAST].vld & w_mrg[LAST].pend) | w_int_take;
  assign w_commit_code = w_int_take ? '0 : w_mrg[LAST].code;
  assign w_epc_nxt     = w_mrg[LAST].bd ? (w_mrg[LAST].pc - PC_W'(4)) : w_mrg[LAST].pc;
  // reset gating keeps flush quiet while reset is held, even if eret is driven
  assign w_flush       = reset_n & (w_exc_commit | bus.eret);

  // stage registers: flush kills everything, stall holds all but the final stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stg <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_stg[i].vld  <= 1'b0;
        r_stg[i].pend <= 1'b0;
      end
    end else if (bus.stall) begin
      r_stg[LAST].vld  <= 1'b0;
      r_stg[LAST].pend <= 1'b0;
    end else begin
      r_stg[0].vld  <= bus.instr_vld_d;
      r_stg[0].pend <= 1'b0;
      r_stg[0].code <= '0;
      r_stg[0].bd   <= bus.bd_d;
      r_stg[0].pc   <= bus.pc_d;
      for (int i = 1; i < NUM_STAGES; i++) r_stg[i] <= w_mrg[i-1];
    end
  end

  // CP0 state: commit beats eret; EPC only captured on first-level entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause_code <= '0;
      r_cause_bd   <= 1'b0;
      r_epc        <= '0;
      r_exl        <= 1'b0;
    end else if (w_exc_commit) begin
      r_cause_code <= w_commit_code;
      r_cause_bd   <= w_mrg[LAST].bd;
      if (!r_exl) begin
        r_epc <= w_epc_nxt;
        r_exl <= 1'b1;
      end
    end else if (bus.eret) begin
      r_exl <= 1'b0;
    end
  end

  assign bus.exc_commit = w_exc_commit;
  assign bus.flush      = w_flush;
  assign bus.cause_code = r_cause_code;
  assign bus.cause_bd   = r_cause_bd;
  assign bus.epc        = r_epc;
  assign bus.exl        = r_exl;
endmodule

// File: tb/tb_exc_pipe_tracker.sv
// tb_exc_pipe_tracker: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an instruction-slot model.
module tb_exc_pipe_tracker;
  localparam int NS = 3;
  localparam int CW = 5;
  localparam int PW = 32;
`ifdef EXC_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  exc_pipe_tracker_if #(.NUM_STAGES(NS), .CODE_W(CW), .PC_W(PW)) bus ();

  exc_pipe_tracker #(.NUM_STAGES(NS), .CODE_W(CW), .PC_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot holds the instruction currently at that stage and the first
  // exception it picked up on its way.
  typedef struct {
    bit          v;
    bit          has_exc;
    bit [CW-1:0] first_code;
    bit          bd;
    bit [PW-1:0] pc;
  } slot_t;

  slot_t       pipe [NS];
  bit [CW-1:0] m_cause;
  bit          m_bd;
  bit [PW-1:0] m_epc;
  bit          m_exl;

  always @(negedge clk) begin
    slot_t       last;
    slot_t       moved;
    bit          intr;
    bit          commit;
    bit [CW-1:0] code;
    if (!reset_n) begin
      foreach (pipe[i]) pipe[i] = '{default: 0};
      m_cause = '0; m_bd = 0; m_epc = '0; m_exl = 0;
      chk("rst_commit", bus.exc_commit, 0);
      chk("rst_flush",  bus.flush, 0);
      chk("rst_out",    {bus.cause_code, bus.cause_bd, bus.exl}, 0);
      chk("rst_epc",    bus.epc, 0);
    end else begin
      last = pipe[NS-1];
`ifdef EXC_INT_EN
      intr = last.v && !m_exl && bus.im_ie[0] && (|(bus.hw_int & bus.im_ie[6:1]));
`else
      intr = 1'b0;
`endif
      code   = last.has_exc ? last.first_code : bus.exc_code[(NS-1)*CW +: CW];
      commit = last.v && (last.has_exc || bus.exc_req[NS-1] || intr);
      if (intr) code = '0;

      chk("m_commit", bus.exc_commit, commit);
      chk("m_flush",  bus.flush, commit | bus.eret);
      chk("m_cause",  bus.cause_code, m_cause);
      chk("m_bd",     bus.cause_bd, m_bd);
      chk("m_epc",    bus.epc, m_epc);
      chk("m_exl",    bus.exl, m_exl);

      // state seen after the coming clock edge
      if (commit) begin
        m_cause = code;
        m_bd    = last.bd;
        if (!m_exl) begin
          m_epc = last.bd ? last.pc - 32'd4 : last.pc;
          m_exl = 1;
        end
      end else if (bus.eret) begin
        m_exl = 0;
      end

      if (commit || bus.eret) begin
        foreach (pipe[i]) pipe[i].v = 0;
      end else if (bus.stall) begin
        pipe[NS-1].v = 0;
      end else begin
        for (int i = NS - 1; i >= 1; i--) begin
          moved = pipe[i-1];
          if (moved.v && !moved.has_exc && bus.exc_req[i-1]) begin
            moved.has_exc    = 1;
            moved.first_code = bus.exc_code[(i-1)*CW +: CW];
          end
          pipe[i] = moved;
        end
        pipe[0] = '{v: bus.instr_vld_d, has_exc: 0, first_code: 0, bd: bus.bd_d, pc: bus.pc_d};
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instr_vld_d = 0; bus.pc_d = '0; bus.bd_d = 0;
    bus.exc_req = '0; bus.exc_code = '0; bus.stall = 0; bus.eret = 0;
    bus.hw_int = '0; bus.im_ie = '0;
  endtask

  task automatic load(input logic [31:0] pc, input logic bd);
    idle();
    bus.instr_vld_d = 1; bus.pc_d = pc; bus.bd_d = bd;
  endtask

  task automatic set_exc(input int st, input logic [CW-1:0] c);
    bus.exc_req[st] = 1'b1;
    bus.exc_code[st*CW +: CW] = c;
  endtask

  task automatic do_eret();
    idle(); bus.eret = 1; #1;
    chk("eret_flush", bus.flush, 1);
    step();
    idle(); #1;
    chk("eret_exl", bus.exl, 0);
    chk("eret_flush_drop", bus.flush, 0);
  endtask

  initial begin
    idle();
    reset_n = 0;
    repeat (3) step();
    reset_n = 1;

    // 1: idle after reset
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t1_flush", bus.flush, 0);
      chk("t1_outs", {bus.exc_commit, bus.cause_code, bus.cause_bd, bus.exl}, 0);
      step();
    end

    // 2: overflow at stage 1; younger instr gets killed
    load(32'h3000, 0); step();
    load(32'h3004, 0); step();
    idle(); set_exc(1, 5'h0C); step();
    idle(); #1;
    chk("t2_commit", bus.exc_commit, 1);
    chk("t2_flush", bus.flush, 1);
    step();
    chk("t2_epc", bus.epc, 32'h3000);
    chk("t2_cause", bus.cause_code, 5'h0C);
    chk("t2_exl", bus.exl, 1);
    for (int k = 0; k < 4; k++) begin
      #1; chk("t2_killed", bus.exc_commit, 0); step();
    end

    // 3: oldest detection wins
    do_eret();
    load(32'h3020, 0); step();
    idle(); set_exc(0, 5'h04); step();
    idle(); set_exc(1, 5'h0C); step();
    idle(); #1;
    chk("t3_commit", bus.exc_commit, 1);
    step();
    chk("t3_cause", bus.cause_code, 5'h04);
    chk("t3_epc", bus.epc, 32'h3020);

    // 4: delay slot, nested exception, eret
    do_eret();
    load(32'h3008, 1); step();
    idle(); step();
    idle(); step();
    set_exc(2, 5'h0A); #1;
    chk("t4_commit", bus.exc_commit, 1);
    step();
    idle();
    chk("t4_epc", bus.epc, 32'h3004);
    chk("t4_bd", bus.cause_bd, 1);
    chk("t4_cause", bus.cause_code, 5'h0A);
    load(32'h3100, 0); step();
    idle(); step();
    idle(); step();
    set_exc(2, 5'h0D); step();
    idle();
    chk("t4_nest_cause", bus.cause_code, 5'h0D);
    chk("t4_nest_epc", bus.epc, 32'h3004);
    chk("t4_nest_exl", bus.exl, 1);
    chk("t4_nest_bd", bus.cause_bd, 0);
    do_eret();

    // 5: stall with exception held in stage 0
    load(32'h3040, 0); step();
    load(32'h3044, 0); step();
    idle(); bus.stall = 1; set_exc(0, 5'h05);
    for (int k = 0; k < 3; k++) begin
      #1; chk("t5_stall_nocommit", bus.exc_commit, 0); step();
    end
    bus.stall = 0; #1;
    chk("t5_s0", bus.exc_commit, 0); step();
    idle(); #1;
    chk("t5_s1", bus.exc_commit, 0); step();
    #1;
    chk("t5_s2", bus.exc_commit, 1); step();
    chk("t5_epc", bus.epc, 32'h3044);
    chk("t5_cause", bus.cause_code, 5'h05);

    // pc wrap on delay-slot EPC
    do_eret();
    load(32'h0, 1); step();
    idle(); step();
    idle(); step();
    set_exc(2, 5'h01); step();
    idle();
    chk("wrap_epc", bus.epc, 32'hFFFF_FFFC);

    // 6: interrupt (taken only when the feature is built in)
    do_eret();
    load(32'h3010, 0); bus.im_ie = 7'b0000011; bus.hw_int = 6'b000001; step();
    idle(); bus.im_ie = 7'b0000011; bus.hw_int = 6'b000001; step();
    step();
    #1;
    chk("t6_int", bus.exc_commit, INT_EN);
    step();
    if (INT_EN) begin
      chk("t6_epc", bus.epc, 32'h3010);
      chk("t6_code", bus.cause_code, 0);
    end
    load(32'h3014, 0); bus.im_ie = 7'b0000011; bus.hw_int = 6'b000001; step();
    idle(); bus.im_ie = 7'b0000011; bus.hw_int = 6'b000001; step();
    step();
    #1;
    chk("t6_masked", bus.exc_commit, 0);
    step();

    // reset mid-flight while an exception is about to commit
    idle();
    load(32'h3200, 0); step();
    idle(); set_exc(1, 5'h07); step();
    idle(); bus.eret = 1;
    reset_n = 0; #1;
    chk("mrst_commit", bus.exc_commit, 0);
    chk("mrst_flush", bus.flush, 0);
    chk("mrst_exl", bus.exl, 0);
    step();
    idle(); reset_n = 1;
    step();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bus.instr_vld_d = ($urandom_range(0, 3) != 0);
      bus.pc_d        = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      bus.bd_d        = $urandom_range(0, 1) == 1;
      for (int s = 0; s < NS; s++) bus.exc_req[s] = ($urandom_range(0, 7) == 0);
      bus.exc_code    = NS*CW'($urandom);
      bus.stall       = ($urandom_range(0, 4) == 0);
      bus.eret        = ($urandom_range(0, 19) == 0);
      bus.hw_int      = 6'($urandom);
      bus.im_ie       = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h0;
      step();
    end
    idle();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
